flash_read_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one read_flash engine among NUM_REQ clients
//  (e.g. audio sample fetcher, key/header reader). Sits between the clients and read_flash.

---
 rtl/flash_arb_pkg.sv | 20 ++
 rtl/flash_read_arbiter_rr_picker.sv | 41 ++++
 rtl/flash_read_arbiter.sv | 148 ++++++++++++++
 tb/tb_flash_read_arbiter.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// ---------------------------------------------------------------------------
// flash_arb_pkg
//   Shared widths and the arbiter state type for flash_read_arbiter.
//   ADDR_W      : flash word address width
//   DATA_W      : flash data word width
//   arb_state_t : IDLE -> READ -> RESP -> DRAIN -> IDLE
// ---------------------------------------------------------------------------
package flash_arb_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RESP,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/flash_read_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin winner selection. Scans the request vector
//   starting one position after last_grant (wrapping) and returns the first
//   set bit.
// Ports
//   req        in   NUM_REQ   request vector
//   last_grant in   IDX_W     index of the previous winner
//   grant      out  NUM_REQ   one-hot winner, zero when req is zero
//   grant_idx  out  IDX_W     index of the winner (0 when req is zero)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // offset NUM_REQ wraps back to last_grant itself, so it has lowest priority
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/flash_read_arbiter.sv
// ---------------------------------------------------------------------------
// flash_read_arbiter
//   Round-robin arbiter/sequencer sharing one read_flash engine among
//   NUM_REQ clients. One transaction at a time: accept, read, respond, drain.
//   Optional read watchdog enabled by defining FLASH_ARB_TIMEOUT_EN.
// Ports
//   clk          in   1            system clock, rising edge
//   reset        in   1            asynchronous, active-low
//   req_valid    in   NUM_REQ      per-client request
//   req_addr     in   NUM_REQ*24   client i address at [24*i +: 24]
//   req_ready    out  NUM_REQ      one-hot accept pulse
//   rsp_valid    out  NUM_REQ      one-hot response pulse
//   rsp_data     out  32           response word
//   rsp_err      out  1            watchdog timeout flag, qualified by rsp_valid
//   start_read   out  1            level request to read_flash
//   request_addr out  24           address to read_flash
//   read_done    in   1            read_flash done
//   read_data    in   32           read_flash data_out
//   busy         out  1            high outside IDLE
// ---------------------------------------------------------------------------
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      start_read,
    output logic [ADDR_W-1:0]         request_addr,
    input  logic                      read_done,
    input  logic [DATA_W-1:0]         read_data,
    output logic                      busy
);

    localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    arb_state_t          state;
    logic [IDX_W-1:0]    last_grant;
    logic [NUM_REQ-1:0]  win_oh;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[ADDR_W*g +: ADDR_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] wd_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign rsp_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= LAST_RST;
            win_oh       <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            start_read   <= 1'b0;
            request_addr <= '0;
            busy         <= 1'b0;
`ifdef FLASH_ARB_TIMEOUT_EN
            rsp_err      <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            // pulse outputs default low; rsp_data is only meaningful with rsp_valid
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
            rsp_err   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready    <= pick_grant;
                        win_oh       <= pick_grant;
                        last_grant   <= pick_idx;
                        request_addr <= addr_arr[pick_idx];
                        start_read   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= READ;
`ifdef FLASH_ARB_TIMEOUT_EN
                        wd_cnt       <= '0;
`endif
                    end
                end
                READ: begin
                    if (read_done) begin
                        rsp_data   <= read_data;
                        rsp_valid  <= win_oh;
                        start_read <= 1'b0;
                        state      <= RESP;
                    end
`ifdef FLASH_ARB_TIMEOUT_EN
                    // done has priority over an expiring watchdog in the same cycle
                    else if (wd_cnt == TMO_LAST) begin
                        rsp_valid  <= win_oh;
                        rsp_err    <= 1'b1;
                        start_read <= 1'b0;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + TMO_W'(1);
                    end
`endif
                end
                RESP: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!read_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_flash_read_arbiter
//   Directed bench for flash_read_arbiter (NUM_REQ = 2). A read_flash model
//   with configurable done delay/length drives read_done/read_data. A
//   transaction-level reference checks every output on every cycle; the
//   directed tests add literal expectations. Honours FLASH_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_flash_read_arbiter;

    localparam int N   = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [47:0] req_addr = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        start_read;
    logic [23:0] request_addr;
    logic        read_done = 1'b0;
    logic [31:0] read_data = '0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    flash_read_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .start_read   (start_read),
        .request_addr (request_addr),
        .read_done    (read_done),
        .read_data    (read_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] data_of(input logic [23:0] a);
        if (a == 24'h000010) return 32'h12345678;
        return {8'hC3, a};
    endfunction

    function automatic int rr_pick(input int last, input logic [1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // read_flash model: done rises done_delay negedges after start_read is seen
    int done_delay = 3;
    int done_len   = 1;
    bit done_never = 1'b0;
    int f_phase = 0;
    int f_wait  = 0;
    int f_hold  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            f_phase   = 0;
            read_done = 1'b0;
        end else begin
            case (f_phase)
                0: if (start_read) begin
                       f_phase = 1;
                       f_wait  = done_delay;
                   end
                1: if (!start_read) begin
                       f_phase = 0;
                   end else if (!done_never) begin
                       f_wait--;
                       if (f_wait <= 0) begin
                           read_done = 1'b1;
                           read_data = data_of(request_addr);
                           f_hold    = done_len;
                           f_phase   = 2;
                       end
                   end
                default: begin
                    f_hold--;
                    if (f_hold <= 0) begin
                        read_done = 1'b0;
                        f_phase   = 0;
                    end
                end
            endcase
        end
    end

    // clients drop req_valid on their accept pulse unless told to keep requesting
    bit persist [2];
    always @(negedge clk) begin
        for (int i = 0; i < N; i++)
            if (req_ready[i] && !persist[i]) req_valid[i] = 1'b0;
    end

    // observation logs used by the directed tests
    int          rdy_cnt [2];
    int          rsp_cnt [2];
    int          grant_q [$];
    logic [23:0] addr_q  [$];

    // transaction-level reference: one transaction owns the engine from accept
    // until the response has been given and done has been seen low afterwards
    bit          m_act = 1'b0;
    bit          m_given = 1'b0;
    bit          m_resp_cycle = 1'b0;
    int          m_w = 0;
    int          m_last = N - 1;
    int          m_rd = 0;
    logic [23:0] m_addr = '0;

    always @(posedge clk) begin
        logic [1:0]  e_ready;
        logic [1:0]  e_rsp;
        logic [31:0] e_data;
        logic        e_err;
        int          w;
        #1;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                rdy_cnt[i]++;
                grant_q.push_back(i);
                addr_q.push_back(request_addr);
            end
            if (rsp_valid[i]) rsp_cnt[i]++;
        end
        if (!rst_n) begin
            m_act = 1'b0; m_given = 1'b0; m_resp_cycle = 1'b0; m_last = N - 1;
            chk("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_err, start_read, request_addr, busy}, 64'd0);
        end else begin
            e_ready = '0; e_rsp = '0; e_data = '0; e_err = 1'b0;
            if (!m_act) begin
                if (req_valid != 2'b00) begin
                    w = rr_pick(m_last, req_valid);
                    e_ready[w] = 1'b1;
                    m_w = w; m_last = w;
                    m_addr = req_addr[24*w +: 24];
                    m_act = 1'b1; m_given = 1'b0; m_rd = 0;
                end
            end else if (!m_given) begin
                if (read_done) begin
                    e_rsp[m_w] = 1'b1; e_data = read_data;
                    m_given = 1'b1; m_resp_cycle = 1'b1;
                end
`ifdef FLASH_ARB_TIMEOUT_EN
                else begin
                    m_rd++;
                    if (m_rd == TMO) begin
                        e_rsp[m_w] = 1'b1; e_err = 1'b1; e_data = '0;
                        m_given = 1'b1; m_resp_cycle = 1'b1;
                    end
                end
`endif
            end else if (m_resp_cycle) begin
                m_resp_cycle = 1'b0;
            end else if (!read_done) begin
                m_act = 1'b0;
            end
            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_rsp);
            chk("busy", busy, m_act);
            chk("start_read", start_read, m_act && !m_given);
            if (m_act && !m_given) chk("request_addr", request_addr, m_addr);
            if (e_rsp != 2'b00) begin
                chk("rsp_data", rsp_data, e_data);
                chk("rsp_err", rsp_err, e_err);
            end else begin
                chk("rsp_err_unqualified", rsp_err, 1'b0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        persist[0] = 1'b0;
        persist[1] = 1'b0;
        done_never = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input int maxc, input string name);
        int n;
        n = 0;
        tick();
        while (rsp_valid == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
        chk(name, rsp_valid != 2'b00, 1'b1);
    endtask

    task automatic wait_ready(input int maxc, input string name);
        int n;
        n = 0;
        tick();
        while (req_ready == 2'b00 && n < maxc) begin
            tick();
            n++;
        end
        chk(name, req_ready != 2'b00, 1'b1);
    endtask

    task automatic wait_quiet(input int maxc, input string name);
        int n;
        n = 0;
        tick();
        while ((busy || req_valid != 2'b00) && n < maxc) begin
            tick();
            n++;
        end
        chk(name, busy || req_valid != 2'b00, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int base;
        int c1r;
        int c1s;
        int exp_g [4];
        logic [23:0] exp_a [4];

        // 1: single client, delay 3
        do_reset();
        chk("t1_idle_busy", busy, 1'b0);
        grant_q.delete(); addr_q.delete();
        done_delay = 3; done_len = 1;
        @(negedge clk);
        req_addr[23:0] = 24'h000010;
        req_valid[0] = 1'b1;
        wait_rsp(40, "t1_rsp_seen");
        chk("t1_rsp_valid", rsp_valid, 2'b01);
        chk("t1_rsp_data", rsp_data, 32'h12345678);
        repeat (4) tick();
        chk("t1_busy_low", busy, 1'b0);
        chk("t1_n_grants", grant_q.size(), 1);
        if (grant_q.size() == 1) begin
            chk("t1_grant", grant_q[0], 0);
            chk("t1_addr", addr_q[0], 24'h000010);
        end

        // 2: both clients always requesting -> strict alternation
        do_reset();
        grant_q.delete(); addr_q.delete();
        done_delay = 2; done_len = 1;
        @(negedge clk);
        persist[0] = 1'b1; persist[1] = 1'b1;
        req_addr[23:0] = 24'h000100;
        req_addr[47:24] = 24'h000200;
        req_valid = 2'b11;
        base = rsp_cnt[0] + rsp_cnt[1];
        n = 0;
        while (rsp_cnt[0] + rsp_cnt[1] < base + 4 && n < 200) begin
            tick();
            n++;
        end
        chk("t2_four_rsps", rsp_cnt[0] + rsp_cnt[1] - base, 4);
        @(negedge clk);
        persist[0] = 1'b0; persist[1] = 1'b0;
        req_valid = 2'b00;
        exp_g = '{0, 1, 0, 1};
        exp_a = '{24'h000100, 24'h000200, 24'h000100, 24'h000200};
        chk("t2_n_grants", grant_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_q.size()) begin
                chk("t2_grant_order", grant_q[i], exp_g[i]);
                chk("t2_addr_order", addr_q[i], exp_a[i]);
            end
        end
        wait_quiet(40, "t2_quiet");

        // 3: done held high for 5 cycles
        do_reset();
        done_delay = 2; done_len = 5;
        @(negedge clk);
        persist[0] = 1'b1;
        req_addr[23:0] = 24'h000333;
        req_valid[0] = 1'b1;
        wait_rsp(40, "t3_rsp_seen");
        n = 0;
        while (read_done && n < 20) begin
            chk("t3_start_low_while_done", start_read, 1'b0);
            chk("t3_busy_while_done", busy, 1'b1);
            tick();
            n++;
        end
        chk("t3_done_held", n >= 3, 1'b1);
        chk("t3_no_start_at_done_fall", start_read, 1'b0);
        n = 0;
        while (!start_read && n < 10) begin
            tick();
            n++;
        end
        chk("t3_restart_gap", n >= 1 && n < 10, 1'b1);
        @(negedge clk);
        persist[0] = 1'b0;
        req_valid[0] = 1'b0;
        wait_rsp(40, "t3_second_rsp");
        wait_quiet(40, "t3_quiet");
        done_len = 1;

        // 4: reset mid-read
        do_reset();
        done_delay = 4;
        @(negedge clk);
        req_addr[47:24] = 24'h000200;
        req_valid[1] = 1'b1;
        wait_ready(10, "t4_ready_seen");
        chk("t4_first_grant_c1", req_ready, 2'b10);
        tick();
        chk("t4_in_read", start_read, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_async_clear", {req_ready, rsp_valid, rsp_data, rsp_err, start_read, request_addr, busy}, 64'd0);
        repeat (2) @(negedge clk);
        req_addr[23:0] = 24'h000010;
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready(10, "t4_post_ready_seen");
        chk("t4_post_reset_grant", req_ready, 2'b01);
        wait_quiet(80, "t4_quiet");

        // 5: client 1 withdraws while client 0 is reading
        do_reset();
        done_delay = 6;
        c1r = rdy_cnt[1];
        c1s = rsp_cnt[1];
        @(negedge clk);
        req_addr[23:0] = 24'h000010;
        req_addr[47:24] = 24'h000020;
        req_valid = 2'b11;
        wait_ready(10, "t5_ready_seen");
        chk("t5_c0_first", req_ready, 2'b01);
        tick();
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_rsp(40, "t5_rsp_seen");
        chk("t5_rsp_c0", rsp_valid, 2'b01);
        repeat (10) tick();
        chk("t5_no_ready_c1", rdy_cnt[1] - c1r, 0);
        chk("t5_no_rsp_c1", rsp_cnt[1] - c1s, 0);
        chk("t5_idle", busy, 1'b0);

        // 6: done never arrives
        do_reset();
        done_never = 1'b1;
        @(negedge clk);
        req_addr[23:0] = 24'h000040;
        req_valid[0] = 1'b1;
        wait_ready(10, "t6_ready_seen");
`ifdef FLASH_ARB_TIMEOUT_EN
        n = 0;
        while (start_read && n < 40) begin
            n++;
            tick();
        end
        chk("t6_read_cycles", n, TMO);
        chk("t6_tmo_rsp_valid", rsp_valid, 2'b01);
        chk("t6_tmo_rsp_err", rsp_err, 1'b1);
        chk("t6_tmo_rsp_data", rsp_data, 32'd0);
        done_never = 1'b0;
        wait_quiet(40, "t6_quiet");
`else
        n = 0;
        repeat (100) begin
            tick();
            if (busy) n++;
        end
        chk("t6_busy_held", n, 100);
        chk("t6_still_reading", start_read, 1'b1);
        do_reset();
`endif

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
